// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: datapath widths, major opcodes, immediate
// formats and opcode classification helpers used by the decode stage.
package rv32i_pkg;

    localparam int RV_XLEN   = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_t;

    // True for the eleven major opcodes of the base integer set.
    function automatic logic opcode_legal(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM:
                opcode_legal = 1'b1;
            default:
                opcode_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate generator: classifies the instruction
// format from the opcode and builds the sign-extended immediate.
// Unknown opcodes are treated as R format and yield a zero immediate.
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [RV_XLEN-1:0] instr,
    output logic [RV_XLEN-1:0] imm,
    output imm_fmt_t           fmt
);

    // Map the major opcode onto its immediate format.
    always_comb begin
        fmt = FMT_R;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC:                              fmt = FMT_U;
            OPC_JAL:                                         fmt = FMT_J;
            OPC_BRANCH:                                      fmt = FMT_B;
            OPC_STORE:                                       fmt = FMT_S;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_FENCE,
            OPC_SYSTEM:                                      fmt = FMT_I;
            default:                                         fmt = FMT_R;
        endcase
    end

    // Assemble the immediate bits for the selected format.
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'b0};
            FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_operand_fetch.sv
// RV32I decode / operand fetch stage. Stage S1 holds a decoded instruction
// whose register_file reads are in flight; stage OUT holds the registered
// bundle offered to execute. Optional macro DECODE_WB_FORWARD_EN latches a
// writeback that coincides with a read so the new value reaches OUT.
module decode_operand_fetch
    import rv32i_pkg::*;
#(
    parameter int          XLEN         = RV_XLEN,
    parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 rd_en1,
    output logic [REG_IDX_W-1:0] rd_index1,
    output logic                 rd_en2,
    output logic [REG_IDX_W-1:0] rd_index2,
    input  logic [XLEN-1:0]      rd_data1,
    input  logic [XLEN-1:0]      rd_data2,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_index,
    input  logic [XLEN-1:0]      wr_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_rs1_data,
    output logic [XLEN-1:0]      out_rs2_data,
    output logic [XLEN-1:0]      out_imm,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic [6:0]           out_opcode,
    output logic [2:0]           out_funct3,
    output logic                 out_funct7b5,
    output logic                 out_illegal
);

    logic [XLEN-1:0]      dec_imm;
    imm_fmt_t             dec_fmt;
    logic                 dec_use1, dec_use2;
    logic                 adv, accept;

    logic                 s1_valid;
    logic [XLEN-1:0]      s1_pc, s1_imm;
    logic [REG_IDX_W-1:0] s1_rd, s1_rs1, s1_rs2;
    logic [6:0]           s1_opcode;
    logic [2:0]           s1_funct3;
    logic                 s1_funct7b5, s1_illegal, s1_use1, s1_use2;

    logic [XLEN-1:0]      op1_src, op2_src;

    rv32i_imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    // Register usage follows the format: U/J have no sources, only
    // OP (R format), STORE and BRANCH read rs2; unknown opcodes read rs1.
    assign dec_use1 = (dec_fmt != FMT_U) && (dec_fmt != FMT_J);
    assign dec_use2 = (dec_fmt == FMT_S) || (dec_fmt == FMT_B) ||
                      ((dec_fmt == FMT_R) && (in_instr[6:0] == OPC_OP));

    assign adv      = s1_valid && (!out_valid || out_ready);
    assign in_ready = !flush && (!s1_valid || adv);
    assign accept   = in_valid && in_ready;

    // Drive the read ports: fresh indices on accept, S1's indices while
    // stalled so rd_data tracks writebacks, nothing in reset or flush.
    always_comb begin
        rd_en1    = 1'b0;
        rd_en2    = 1'b0;
        rd_index1 = in_instr[19:15];
        rd_index2 = in_instr[24:20];
        if (!reset && !flush) begin
            if (accept) begin
                rd_en1 = dec_use1;
                rd_en2 = dec_use2;
            end else if (s1_valid && !adv) begin
                rd_en1    = s1_use1;
                rd_en2    = s1_use2;
                rd_index1 = s1_rs1;
                rd_index2 = s1_rs2;
            end
        end
    end

    // S1 register: load decoded fields on accept, drain on advance.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid    <= 1'b1;
            s1_pc       <= in_pc;
            s1_imm      <= dec_imm;
            s1_rd       <= in_instr[11:7];
            s1_rs1      <= in_instr[19:15];
            s1_rs2      <= in_instr[24:20];
            s1_opcode   <= in_instr[6:0];
            s1_funct3   <= in_instr[14:12];
            s1_funct7b5 <= in_instr[30];
            s1_illegal  <= !opcode_legal(in_instr[6:0]);
            s1_use1     <= dec_use1;
            s1_use2     <= dec_use2;
        end else if (adv) begin
            s1_valid <= 1'b0;
        end
    end

`ifdef DECODE_WB_FORWARD_EN
    logic            byp1_hit, byp2_hit;
    logic [XLEN-1:0] byp1_data, byp2_data;

    // Capture a writeback that lands on the same edge as a read, since the
    // register file returns the old value in that case.
    always_ff @(posedge clk) begin
        if (reset) begin
            byp1_hit  <= 1'b0;
            byp2_hit  <= 1'b0;
            byp1_data <= '0;
            byp2_data <= '0;
        end else begin
            if (rd_en1) begin
                byp1_hit  <= wr_en && (wr_index == rd_index1) && (rd_index1 != '0);
                byp1_data <= wr_data;
            end
            if (rd_en2) begin
                byp2_hit  <= wr_en && (wr_index == rd_index2) && (rd_index2 != '0);
                byp2_data <= wr_data;
            end
        end
    end

    assign op1_src = byp1_hit ? byp1_data : rd_data1;
    assign op2_src = byp2_hit ? byp2_data : rd_data2;
`else
    logic unused_wb;
    assign unused_wb = ^{wr_en, wr_index, wr_data};
    assign op1_src   = rd_data1;
    assign op2_src   = rd_data2;
`endif

    // OUT register: capture S1 plus operand data on advance, hold under
    // backpressure, empty when execute takes the bundle or on flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_pc       <= RESET_PC_TAG;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7b5 <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid    <= 1'b1;
            out_pc       <= s1_pc;
            out_rs1_data <= s1_use1 ? op1_src : '0;
            out_rs2_data <= s1_use2 ? op2_src : '0;
            out_imm      <= s1_imm;
            out_rd       <= s1_rd;
            out_opcode   <= s1_opcode;
            out_funct3   <= s1_funct3;
            out_funct7b5 <= s1_funct7b5;
            out_illegal  <= s1_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/decode_operand_fetch.md
Name: decode_operand_fetch

Overview:
- RV32I decode stage sitting directly upstream of register_file.
- Accepts fetched instructions on a valid/ready handshake, decodes fields and the immediate, and drives the two register_file read ports.
- Captures the operand data and presents a registered decoded bundle to execute on a second valid/ready handshake.
- Two internal stages: S1 (read issued, data pending) and OUT (output register).

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- RESET_PC_TAG, 32'h0, value driven on out_pc while reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  drop S1 and OUT contents (branch redirect).
- in_valid  in  1  instruction valid.
- in_ready  out  1  instruction accepted when in_valid & in_ready.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- rd_en1  out  1  register_file read port 1 enable.
- rd_index1  out  5  read port 1 index.
- rd_en2  out  1  read port 2 enable.
- rd_index2  out  5  read port 2 index.
- rd_data1  in  32  register_file read data 1.
- rd_data2  in  32  register_file read data 2.
- wr_en  in  1  writeback snoop, mirrors the register_file write port.
- wr_index  in  5  writeback snoop index.
- wr_data  in  32  writeback snoop data.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  32  bundle pc.
- out_rs1_data  out  32  operand 1 value.
- out_rs2_data  out  32  operand 2 value.
- out_imm  out  32  sign-extended immediate.
- out_rd  out  5  destination register index.
- out_opcode  out  7  opcode field.
- out_funct3  out  3  funct3 field.
- out_funct7b5  out  1  instr[30].
- out_illegal  out  1  opcode not in the RV32I set.

Behaviour:
- Reset (synchronous, active-high): S1 valid=0; out_valid=0; every out_* data output=0 except out_pc=RESET_PC_TAG; rd_en1/rd_en2 = 0.
- register_file contract: indices are sampled at the edge where rd_en=1, and data is valid the following cycle. A read coinciding with a write to the same index returns the OLD value. Index 0 always reads 0.
- Handshake control:
  - adv = S1_valid & (!out_valid | out_ready).
  - in_ready = !flush & (!S1_valid | adv). This is combinational.
- Accept edge N: S1 loads the decoded fields. Read ports are driven from in_instr during cycle N: rd_en1 = accept & uses_rs1, rd_en2 = accept & uses_rs2.
- uses_rs1 is set for all opcodes except LUI, AUIPC and JAL. uses_rs2 is set for OP, STORE and BRANCH.
- Edge N+1, when adv: OUT captures rd_data plus the S1 fields, and out_valid=1. Minimum latency is 2 cycles; throughput is 1 instruction per cycle.
- S1 stalled (S1_valid & !adv): the read ports re-issue S1's indices every cycle, so rd_data stays current with intervening writebacks.
- Operands that are not used are forced to 0.
- OUT holds stable while out_valid & !out_ready.
- Immediate formats: I/S/B/U/J per RV32I, sign-extended from instr[31]. The R format gives 0.
- out_illegal=1 for opcodes other than LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE, SYSTEM. Illegal instructions still flow through the stage.
- flush: S1_valid and out_valid clear at the next edge, with priority over accept and adv. rd_en is 0 during the flush cycle.
- Simultaneous accept and adv: S1 refills while OUT captures the old S1 contents, with no bubble.
- Reset mid-operation: all in-flight entries are lost and no read enables are driven in the reset cycle.

Optional Feature:
- Macro DECODE_WB_FORWARD_EN.
- Defined: at each read edge, if wr_en & wr_index==rs & rs!=0, wr_data is latched into a per-port bypass register. When OUT captures, it uses the bypass value instead of rd_data, so read-during-write returns the NEW value.
- Undefined: no snooping; wr_* inputs are ignored, and the upstream hazard unit must stall such a read by one cycle.

Decomposition:
- Package rv32i_pkg: opcode constants (OPC_LUI ... OPC_SYSTEM), immediate-format enum, XLEN and register-index width constants.
- One sub-module, rv32i_imm_gen: purely combinational; takes instr and outputs imm plus format.

Test Plan:
- Back-to-back flow: registers x1..x3 preloaded with 1, 2, 3; issue ADD x4,x1,x2 then ADD x5,x2,x3 on consecutive cycles with out_ready=1 -> out_valid in cycles N+2 and N+3, with operands (1,2) then (2,3).
- Backpressure: out_ready=0 for 3 cycles with two instructions in flight -> in_ready=0, OUT stable, rd_en re-asserted with S1's indices. On release, both bundles emerge in order with no loss or duplication.
- Read-during-write: ADDI x6,x1,0 read issued on the same edge as a writeback of x1=32'hFF -> out_rs1_data=32'hFF with DECODE_WB_FORWARD_EN, old value 32'h1 without it.
- Immediates: SW, BEQ, LUI, JAL with instr[31]=1 -> correct negative sign-extension; LUI out_imm = instr[31:12]<<12; R-type -> out_imm=0; x0 reads give 0.
- Flush and reset: assert flush with S1 and OUT both valid -> out_valid=0 next cycle and no stray rd_en. Reset mid-stall -> all outputs at their reset values after one edge.
- Illegal opcode 7'h7F -> out_illegal=1 and the bundle still delivered; rd_en1=1 and rd_en2=0.
